// File: rtl/vscale_tohost_monitor.sv
// vscale_tohost_monitor: snoops the dmem write bus for tohost/console writes,
// produces a sticky pass/fail/timeout verdict and buffers console bytes.
module vscale_tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h00001000,
    parameter logic [31:0] CONSOLE_ADDR = 32'h00001004,
    parameter int unsigned CON_DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dmem_write,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [63:0] max_cycles,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [31:0] fail_code,
    output logic [63:0] cycle_count,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic        con_overflow
);

    localparam int unsigned PW = $clog2(CON_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(CON_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PASS,
        ST_FAIL_CODE,
        ST_FAIL_TIMEOUT
    } state_t;

    state_t      state;
    logic [31:0] tohost_q;
    logic        tohost_v;
    logic [31:0] code_q;
    logic [63:0] cyc_q;

    logic [7:0]  mem [CON_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic tohost_hit;
    logic con_push;
    logic con_pop;
    logic con_full;
    logic do_push;

    assign tohost_hit = dmem_write && (dmem_addr == TOHOST_ADDR);
    assign con_push   = dmem_write && (dmem_addr == CONSOLE_ADDR);
    assign con_full   = (count == FULL_CNT);
    assign con_valid  = (count != '0);
    assign con_pop    = con_valid && con_ready;
    // A push into a full FIFO only lands if the head leaves on the same edge.
    assign do_push    = con_push && (!con_full || con_pop);
    assign con_data   = mem[rd_ptr];
    assign cycle_count = cyc_q;

    // Capture stage: register the tohost write for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_q <= '0;
            tohost_v <= 1'b0;
        end else begin
            tohost_v <= tohost_hit;
            if (tohost_hit) begin
                tohost_q <= dmem_wdata;
            end
        end
    end

    // Verdict state machine and cycle counter; terminal states are sticky.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_RUN;
            code_q <= '0;
            cyc_q  <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (tohost_v && tohost_q == 32'd1) begin
                        state <= ST_PASS;
                    end else if (tohost_v && tohost_q > 32'd1) begin
                        state  <= ST_FAIL_CODE;
                        code_q <= {1'b0, tohost_q[31:1]};
                    end else if (max_cycles != '0 && cyc_q == max_cycles) begin
                        state <= ST_FAIL_TIMEOUT;
                    end else begin
                        cyc_q <= cyc_q + 64'd1;
                    end
                end
                default: state <= state;
            endcase
        end
    end

    // Registered output decode, one cycle behind the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            timeout   <= 1'b0;
            fail_code <= '0;
        end else begin
            done      <= (state != ST_RUN);
            pass      <= (state == ST_PASS);
            timeout   <= (state == ST_FAIL_TIMEOUT);
            fail_code <= (state == ST_FAIL_CODE) ? code_q : '0;
        end
    end

    // Console FIFO: storage, pointers, occupancy and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            con_overflow <= 1'b0;
            for (int unsigned i = 0; i < CON_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= dmem_wdata[7:0];
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (con_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, con_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (con_push && !do_push) begin
                con_overflow <= 1'b1;
            end
        end
    end

endmodule

// File: doc/vscale_tohost_monitor.md
Name: vscale_tohost_monitor

Overview:
- Synthesizable snooper on the vscale data-memory write bus.
- Detects writes to the tohost and console addresses and turns them into a sticky pass/fail/timeout verdict plus a buffered console byte stream.
- Sits between the core's dmem interface and the simulation or FPGA harness, which only waits on done/pass.
- Replaces ad-hoc testbench decode so the same checker runs under Verilator and on hardware.

Parameters:
- TOHOST_ADDR, 32'h00001000, byte address whose writes carry the test result.
- CONSOLE_ADDR, 32'h00001004, byte address whose writes push wdata[7:0] to the console FIFO.
- CON_DEPTH, 4, console FIFO entries (power of two, >=2).

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- dmem_write  in  1  write strobe for the current bus cycle.
- dmem_addr  in  32  write address.
- dmem_wdata  in  32  write data.
- max_cycles  in  64  cycle limit; 0 = unlimited; quasi-static.
- done  out  1  verdict reached (sticky).
- pass  out  1  tohost==1 verdict (sticky).
- timeout  out  1  cycle-limit verdict (sticky).
- fail_code  out  32  tohost>>1 on code failure, else 0.
- cycle_count  out  64  cycles spent in RUN.
- con_valid  out  1  console byte available.
- con_data  out  8  FIFO head byte.
- con_ready  in  1  consumer accepts head.
- con_overflow  out  1  sticky: a console byte was dropped.

Behaviour:
- Reset: synchronous. All outputs 0, FIFO empty, state RUN, capture register invalid. Reset asserted mid-run aborts everything with no residue.
- Capture stage:
  - Edge where dmem_write=1 and dmem_addr==TOHOST_ADDR: tohost_q<=dmem_wdata, tohost_v<=1.
  - Otherwise tohost_v<=0.
  - Full 32-bit address compare.
- State machine: RUN, PASS, FAIL_CODE, FAIL_TIMEOUT. All states other than RUN are terminal and sticky until reset.
- RUN transitions, evaluated at each edge in priority order:
  1. tohost_v && tohost_q==1 -> PASS.
  2. tohost_v && tohost_q>1 -> FAIL_CODE; fail_code<=tohost_q>>1 (logical shift, bit31=0).
  3. max_cycles!=0 && cycle_count==max_cycles -> FAIL_TIMEOUT.
  4. tohost_v && tohost_q==0 -> ignored; stay in RUN.
- Latency: write sampled at edge N; done/pass/fail_code visible after edge N+2.
- Output decode: done=1 in any terminal state; pass=1 only in PASS; timeout=1 only in FAIL_TIMEOUT.
- Tohost writes arriving in a terminal state are ignored.
- cycle_count:
  - Increments by 1 each edge while in RUN and not transitioning.
  - Frozen in terminal states.
  - Wraps at 2^64 (no saturation).
- Console FIFO:
  - Push on edge with dmem_write=1 and dmem_addr==CONSOLE_ADDR; data is dmem_wdata[7:0]. Pushes accepted in any state.
  - Pop on edge with con_valid && con_ready.
  - con_valid=!empty; con_data=head entry, combinational from storage. No bypass: a pushed byte is visible the cycle after push.
  - Push while full with no pop: byte dropped, con_overflow<=1 (sticky).
  - Push and pop in the same edge while full: both occur, no drop, count unchanged.
  - Push and pop while count==1: head advances to the new byte.
  - Pointers wrap modulo CON_DEPTH; count width log2(CON_DEPTH)+1.
  - FIFO keeps draining after done.
- The two address decodes are mutually exclusive by parameter rule; TOHOST_ADDR!=CONSOLE_ADDR is required.

Test Plan:
- Write 32'h1 to 0x1000 at edge 20 -> done=pass=1 after edge 22; fail_code=0; cycle_count frozen at 21.
- Write 32'd15 to 0x1000 -> done=1, pass=0, fail_code=7; a later write of 1 does not change the state.
- Write 0 to 0x1000, then max_cycles=10 with no further writes -> no verdict from the 0 write; timeout=done=1 once cycle_count==10; cycle_count stays 10.
- max_cycles=5 with tohost=1 captured on the same edge cycle_count reaches 5 -> PASS wins; timeout=0.
- con_ready=0, push bytes 'A','B','C','D','E' -> bytes 'A'..'D' held, 'E' dropped, con_overflow=1. Then con_ready=1 -> con_data sequence A,B,C,D, then con_valid=0.
- Full FIFO, push 'X' and pop in the same edge -> no overflow; drain order is B,C,D,X.
- Assert reset for 1 cycle after FAIL_CODE with 2 bytes buffered -> all outputs 0, FIFO empty, and a subsequent tohost=1 write yields pass.
